// File: rtl/appr_mult_pkg.sv
// Shared constants and the 2x2 digit multiply used by the approximate multiplier pipe.
// The approximate unit maps 3*3 to 7 (binary 111), dropping one bit of the exact 9.
package appr_mult_pkg;

    localparam int          DIG_W     = 2;
    localparam int          UNIT_W    = 4;
    localparam logic [3:0]  APPROX_33 = 4'd7;
    localparam logic [3:0]  EXACT_33  = 4'd9;

    function automatic logic [UNIT_W-1:0] unit2_mul(
        input logic [DIG_W-1:0] a,
        input logic [DIG_W-1:0] b,
        input logic             approx
    );
        if (a == 2'd3 && b == 2'd3) begin
            return approx ? APPROX_33 : EXACT_33;
        end
        return {2'b00, a} * {2'b00, b};
    endfunction

endpackage

// File: rtl/appr_mult_unit2.sv
// Combinational 2x2 digit multiplier; hit_o flags that the approximate 3*3 path was taken.
module appr_mult_unit2
    import appr_mult_pkg::*;
(
    input  logic [DIG_W-1:0]  a_i,
    input  logic [DIG_W-1:0]  b_i,
    input  logic              mode_i,
    output logic [UNIT_W-1:0] prod_o,
    output logic              hit_o
);

    assign prod_o = unit2_mul(a_i, b_i, mode_i);
    assign hit_o  = mode_i & (a_i == 2'd3) & (b_i == 2'd3);

endmodule

// File: rtl/appr_mult_pipe.sv
// Three-stage pipelined unsigned approximate multiplier with valid/ready, per-result
// approximation flag and a saturating count of delivered approximate results.
module appr_mult_pipe
    import appr_mult_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic               iClk,
    input  logic               iRst,
    input  logic               iValid,
    output logic               oReady,
    input  logic [WIDTH-1:0]   iData1,
    input  logic [WIDTH-1:0]   iData2,
    input  logic               iMode,
    output logic               oValid,
    input  logic               iReady,
    output logic [2*WIDTH-1:0] oResult,
    output logic               oApproxHit,
    output logic [CNT_W-1:0]   oHitCnt
);

    localparam int NDIG = WIDTH / DIG_W;
    localparam int PW   = 2 * WIDTH;

    // Handshake: input transfers when iValid & oReady, output when oValid & iReady.
    // The whole pipe advances as one (en); a stalled output freezes every stage, bubbles included.
    logic en;

    logic [WIDTH-1:0]  op1_q, op2_q;
    logic              mode_q, v1_q;

    logic [UNIT_W-1:0]    prod [NDIG][NDIG];
    logic [NDIG*NDIG-1:0] hit_vec;
    logic [PW-1:0]        unit_ext;
    logic [PW-1:0]        row_d [NDIG];
    logic [PW-1:0]        row_q [NDIG];
    logic                 hit_d, hit_q, v2_q;

    logic [PW-1:0]     result_d, result_q;
    logic              ahit_q, v3_q;
    logic [CNT_W-1:0]  cnt_q;

    assign en     = !v3_q || iReady;
    assign oReady = en;

    for (genvar gi = 0; gi < NDIG; gi++) begin : g_row
        for (genvar gj = 0; gj < NDIG; gj++) begin : g_col
            appr_mult_unit2 u_unit (
                .a_i    (op1_q[DIG_W*gi +: DIG_W]),
                .b_i    (op2_q[DIG_W*gj +: DIG_W]),
                .mode_i (mode_q),
                .prod_o (prod[gi][gj]),
                .hit_o  (hit_vec[gi*NDIG + gj])
            );
        end
    end

    always_comb begin
        unit_ext = '0;
        for (int j = 0; j < NDIG; j++) begin
            row_d[j] = '0;
            for (int i = 0; i < NDIG; i++) begin
                unit_ext               = '0;
                unit_ext[UNIT_W-1:0]   = prod[i][j];
                row_d[j]               = row_d[j] + (unit_ext << (DIG_W*i));
            end
        end
        hit_d = |hit_vec;
    end

    // Wraps modulo 2^PW by construction; the approximate product never exceeds the exact one.
    always_comb begin
        result_d = '0;
        for (int j = 0; j < NDIG; j++) begin
            result_d = result_d + (row_q[j] << (DIG_W*j));
        end
    end

    always_ff @(posedge iClk) begin
        if (iRst) begin
            op1_q    <= '0;
            op2_q    <= '0;
            mode_q   <= 1'b0;
            v1_q     <= 1'b0;
            for (int j = 0; j < NDIG; j++) row_q[j] <= '0;
            hit_q    <= 1'b0;
            v2_q     <= 1'b0;
            result_q <= '0;
            ahit_q   <= 1'b0;
            v3_q     <= 1'b0;
            cnt_q    <= '0;
        end else begin
            if (en) begin
                op1_q    <= iData1;
                op2_q    <= iData2;
                mode_q   <= iMode;
                v1_q     <= iValid;
                for (int j = 0; j < NDIG; j++) row_q[j] <= row_d[j];
                hit_q    <= hit_d;
                v2_q     <= v1_q;
                result_q <= result_d;
                ahit_q   <= hit_q;
                v3_q     <= v2_q;
            end
            if (v3_q && iReady && ahit_q && cnt_q != '1) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    assign oValid     = v3_q;
    assign oResult    = result_q;
    assign oApproxHit = ahit_q;
    assign oHitCnt    = cnt_q;

endmodule

// File: tb/tb_appr_mult_pipe.sv
// Bench for appr_mult_pipe: three widths side by side (4, 8 with a 2-bit counter, 16),
// an exact-minus-error product model, per-width expected queues and directed literal checks.
module tb_appr_mult_pipe;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic vld = 1'b0;
    logic rdy = 1'b0;
    logic mode = 1'b0;
    logic [3:0]  a4 = '0, b4 = '0;
    logic [7:0]  a8 = '0, b8 = '0;
    logic [15:0] a16 = '0, b16 = '0;

    logic        o_ready [3];
    logic        o_valid [3];
    logic        o_hit   [3];
    logic [31:0] o_res   [3];
    logic [15:0] o_cnt   [3];
    logic [7:0]  res4;
    logic [15:0] res8, cnt4, cnt16;
    logic [1:0]  cnt8;

    always #5 clk = ~clk;

    appr_mult_pipe #(.WIDTH(4), .CNT_W(16)) dut4 (
        .iClk(clk), .iRst(rst), .iValid(vld), .oReady(o_ready[0]), .iData1(a4), .iData2(b4),
        .iMode(mode), .oValid(o_valid[0]), .iReady(rdy), .oResult(res4),
        .oApproxHit(o_hit[0]), .oHitCnt(cnt4));
    appr_mult_pipe #(.WIDTH(8), .CNT_W(2)) dut8 (
        .iClk(clk), .iRst(rst), .iValid(vld), .oReady(o_ready[1]), .iData1(a8), .iData2(b8),
        .iMode(mode), .oValid(o_valid[1]), .iReady(rdy), .oResult(res8),
        .oApproxHit(o_hit[1]), .oHitCnt(cnt8));
    appr_mult_pipe #(.WIDTH(16), .CNT_W(16)) dut16 (
        .iClk(clk), .iRst(rst), .iValid(vld), .oReady(o_ready[2]), .iData1(a16), .iData2(b16),
        .iMode(mode), .oValid(o_valid[2]), .iReady(rdy), .oResult(o_res[2]),
        .oApproxHit(o_hit[2]), .oHitCnt(cnt16));

    assign o_res[0] = {24'b0, res4};
    assign o_res[1] = {16'b0, res8};
    assign o_cnt[0] = cnt4;
    assign o_cnt[1] = {14'b0, cnt8};
    assign o_cnt[2] = cnt16;

    int tests = 0;
    int fails = 0;

    logic [32:0] exp_q [3][$];
    logic [31:0] dlv8 [$];
    int          cnt_m  [3];
    logic        hold_p [3];
    logic [32:0] held   [3];

    logic        s_valid, s_ready, s_hit, s_acc;
    logic [31:0] s_res;
    logic [15:0] s_cnt;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Exact product minus 2*4^(i+j) for every digit pair that is 3*3 in approximate mode.
    function automatic logic [32:0] model(input logic [15:0] a, input logic [15:0] b,
                                          input logic m, input int w);
        longint exact, err;
        logic   hit;
        exact = longint'(a) * longint'(b);
        err   = 0;
        hit   = 1'b0;
        for (int i = 0; i < w/2; i++) begin
            for (int j = 0; j < w/2; j++) begin
                if (m && ((a >> (2*i)) & 16'h3) == 16'h3 && ((b >> (2*j)) & 16'h3) == 16'h3) begin
                    hit = 1'b1;
                    err += longint'(2) << (2*(i+j));
                end
            end
        end
        return {hit, 32'(exact - err)};
    endfunction

    task automatic mon(input int k);
        logic [15:0] a, b;
        logic [32:0] e, got;
        int          w, cmax;
        case (k)
            0:       begin a = {12'b0, a4}; b = {12'b0, b4}; w = 4;  cmax = 65535; end
            1:       begin a = {8'b0, a8};  b = {8'b0, b8};  w = 8;  cmax = 3;     end
            default: begin a = a16;         b = b16;         w = 16; cmax = 65535; end
        endcase
        got = {o_hit[k], o_res[k]};
        if (rst) begin
            exp_q[k].delete();
            cnt_m[k]  = 0;
            hold_p[k] = 1'b0;
            return;
        end
        if (hold_p[k]) begin
            check($sformatf("hold_valid_w%0d", w), 64'(o_valid[k]), 64'd1);
            check($sformatf("hold_data_w%0d", w), 64'(got), 64'(held[k]));
        end
        check($sformatf("hitcnt_w%0d", w), 64'(o_cnt[k]), 64'(cnt_m[k]));
        check($sformatf("ready_w%0d", w), 64'(o_ready[k]), 64'(!o_valid[k] || rdy));
        if (o_valid[k] && rdy) begin
            if (exp_q[k].size() == 0) begin
                tests++;
                fails++;
                $display("FAIL spurious_w%0d: got result %0d expected no output", w, o_res[k]);
            end else begin
                e = exp_q[k].pop_front();
                check($sformatf("result_w%0d", w), 64'(got), 64'(e));
                if (e[32] && cnt_m[k] < cmax) cnt_m[k]++;
            end
            if (k == 1) dlv8.push_back(o_res[1]);
        end
        hold_p[k] = o_valid[k] && !rdy;
        held[k]   = got;
        if (vld && o_ready[k]) exp_q[k].push_back(model(a, b, mode, w));
    endtask

    task automatic step();
        @(negedge clk);
        s_valid = o_valid[1];
        s_ready = o_ready[1];
        s_hit   = o_hit[1];
        s_res   = o_res[1];
        s_cnt   = o_cnt[1];
        s_acc   = vld && o_ready[1] && !rst;
        for (int k = 0; k < 3; k++) mon(k);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        vld = 1'b0;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic push_op(input logic [7:0] a, input logic [7:0] b, input logic m);
        a8   = a;
        b8   = b;
        mode = m;
        vld  = 1'b1;
        for (int n = 0; n < 50; n++) begin
            step();
            if (s_acc) begin
                vld = 1'b0;
                return;
            end
        end
        tests++;
        fails++;
        $display("FAIL accept_timeout: got no accept expected accept within 50 cycles");
        vld = 1'b0;
    endtask

    task automatic rand_ops();
        a4  = 4'($urandom);
        b4  = 4'($urandom);
        a8  = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom);
        b8  = 8'($urandom);
        a16 = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom);
        b16 = 16'($urandom);
        mode = 1'($urandom);
    endtask

    task automatic expect_out(input string name, input logic [31:0] res, input logic hit);
        step();
        check({name, "_c1_valid"}, 64'(s_valid), 64'd0);
        step();
        check({name, "_c2_valid"}, 64'(s_valid), 64'd0);
        step();
        check({name, "_c3_valid"}, 64'(s_valid), 64'd1);
        check({name, "_res"}, 64'(s_res), 64'(res));
        check({name, "_hit"}, 64'(s_hit), 64'(hit));
    endtask

    initial begin
        logic [31:0] bp_exp [4];
        int          sat_exp [5];
        int          acc_n;
        bp_exp  = '{32'd1, 32'd4, 32'd9, 32'd16};
        sat_exp = '{1, 2, 3, 3, 3};

        do_reset();
        step();
        check("reset_valid", 64'(s_valid), 64'd0);
        check("reset_res", 64'(s_res), 64'd0);
        check("reset_hit", 64'(s_hit), 64'd0);
        check("reset_cnt", 64'(s_cnt), 64'd0);

        check("model_255x255_approx", 64'(model(16'd255, 16'd255, 1'b1, 8)), {31'b0, 1'b1, 32'd50575});
        check("model_255x255_exact", 64'(model(16'd255, 16'd255, 1'b0, 8)), 64'd65025);
        check("model_12x5_approx", 64'(model(16'd12, 16'd5, 1'b1, 8)), 64'd60);
        check("model_3x3_approx", 64'(model(16'd3, 16'd3, 1'b1, 8)), {31'b0, 1'b1, 32'd7});

        rdy = 1'b1;
        push_op(8'd255, 8'd255, 1'b1);
        expect_out("lat_255x255_m1", 32'd50575, 1'b1);
        push_op(8'd255, 8'd255, 1'b0);
        expect_out("lat_255x255_m0", 32'd65025, 1'b0);

        do_reset();
        rdy = 1'b1;
        push_op(8'd12, 8'd5, 1'b1);
        expect_out("12x5_m1", 32'd60, 1'b0);
        push_op(8'd3, 8'd3, 1'b1);
        expect_out("3x3_m1", 32'd7, 1'b1);
        step();
        check("3x3_m1_cnt", 64'(s_cnt), 64'd1);
        push_op(8'd3, 8'd3, 1'b0);
        expect_out("3x3_m0", 32'd9, 1'b0);

        // Backpressure: fill the pipe with the output stalled, then drain in order.
        dlv8.delete();
        rdy = 1'b0;
        push_op(8'd1, 8'd1, 1'b0);
        push_op(8'd2, 8'd2, 1'b0);
        push_op(8'd3, 8'd3, 1'b0);
        a8  = 8'd4;
        b8  = 8'd4;
        vld = 1'b1;
        for (int n = 0; n < 3; n++) begin
            step();
            check("bp_ready_low", 64'(s_ready), 64'd0);
            check("bp_valid_held", 64'(s_valid), 64'd1);
            check("bp_res_held", 64'(s_res), 64'd1);
        end
        rdy = 1'b1;
        push_op(8'd4, 8'd4, 1'b0);
        for (int n = 0; n < 6; n++) step();
        check("bp_count", 64'(dlv8.size()), 64'd4);
        for (int n = 0; n < 4; n++) begin
            if (n < dlv8.size()) check($sformatf("bp_order_%0d", n), 64'(dlv8[n]), 64'(bp_exp[n]));
        end

        // Reset with two operations in flight; neither may ever appear.
        push_op(8'd3, 8'd3, 1'b1);
        push_op(8'd3, 8'd3, 1'b1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        dlv8.delete();
        step();
        check("midrst_valid", 64'(s_valid), 64'd0);
        check("midrst_cnt", 64'(s_cnt), 64'd0);
        for (int n = 0; n < 6; n++) step();
        check("midrst_no_output", 64'(dlv8.size()), 64'd0);

        // 2-bit hit counter on the 8-bit instance saturates at 3.
        for (int n = 0; n < 5; n++) begin
            push_op(8'd3, 8'd3, 1'b1);
            for (int c = 0; c < 4; c++) step();
            check($sformatf("sat_cnt_%0d", n), 64'(s_cnt), 64'(sat_exp[n]));
        end
        push_op(8'd12, 8'd5, 1'b1);
        for (int c = 0; c < 4; c++) step();
        check("sat_nohit_cnt", 64'(s_cnt), 64'd3);

        do_reset();
        acc_n = 0;
        for (int c = 0; c < 8000 && acc_n < 1000; c++) begin
            if (!vld) begin
                rand_ops();
                vld = ($urandom_range(0, 3) != 0);
            end
            rdy = ($urandom_range(0, 3) != 0);
            step();
            if (s_acc) begin
                acc_n++;
                vld = 1'b0;
            end
        end
        check("sweep_ops", 64'(acc_n), 64'd1000);
        vld = 1'b0;
        rdy = 1'b1;
        for (int n = 0; n < 8; n++) step();
        for (int k = 0; k < 3; k++) check($sformatf("drain_%0d", k), 64'(exp_q[k].size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/appr_mult_pipe.md
Name: appr_mult_pipe

Overview:
Parametrised, pipelined unsigned approximate multiplier. It is the next generation of the fixed 8x8 single-register approximate multiplier. Both operands are split into 2-bit digits. Each digit pair is multiplied by a 2x2 unit that is approximate (3*3 -> 7) or exact (3*3 -> 9), selected per operation. The block adds a valid/ready handshake, a 3-stage pipeline with backpressure, a per-result approximation-hit flag, and a saturating hit counter. It sits in the PE datapath of the systolic array, feeding the accumulators.

Parameters:
WIDTH, 8, operand width in bits; must be even and >= 2; NDIG = WIDTH/2 digits
CNT_W, 16, width of the saturating approximation-hit counter

Ports:
iClk  input  1  clock
iRst  input  1  reset
iValid  input  1  input operands valid
oReady  output  1  block can accept input this cycle
iData1  input  WIDTH  multiplicand, unsigned
iData2  input  WIDTH  multiplier, unsigned
iMode  input  1  1 = approximate 2x2 units, 0 = exact
oValid  output  1  result valid
iReady  input  1  downstream accepts result
oResult  output  2*WIDTH  product, exact-width, no truncation
oApproxHit  output  1  this result differs from the exact product
oHitCnt  output  CNT_W  count of delivered results with oApproxHit=1, saturating

Behaviour:
- Reset: iClk and iRst, synchronous, active-high.
  - All stage valid bits, oValid, oResult, oApproxHit and oHitCnt clear to 0.
  - Reset mid-operation flushes every in-flight operation; none is delivered.
- Enable: global stage enable en = !oValid | iReady.
  - oReady = en (combinational).
  - A transfer occurs when iValid & oReady.
  - When en=0, every stage register holds, including the data registers of invalid stages.
  - Bubbles are not collapsed.
- S1 (input register): on en, latch iData1, iData2, iMode and valid = iValid.
- S2 (digit products and rows): on en, from the S1 registers:
  - Unit u(i,j) = d1[i]*d2[j], 4 bits wide, for i,j in 0..NDIG-1.
  - If mode=1 and d1[i]=d2[j]=3, the unit yields 7.
  - Row j = sum over i of u(i,j) << 2i, register width 2*WIDTH.
  - hit = mode & OR over all (i,j) of (d1[i]==3 & d2[j]==3).
  - Register rows, hit and valid.
- S3 (output): on en:
  - oResult = sum over j of row_j << 2j, computed modulo 2^(2*WIDTH).
  - This cannot overflow, because approx <= exact < 2^(2*WIDTH).
  - oApproxHit = hit; oValid = S2 valid.
- Latency: 3 cycles from accept to oValid when iReady stays high; throughput 1 per cycle.
- Output hold: while oValid & !iReady, oResult, oApproxHit and oValid are held stable, and oReady = 0.
- Error magnitude: exact - approx = sum over hit pairs of 2 * 4^(i+j).
- oHitCnt: increments by 1 on each delivered result (oValid & iReady) with oApproxHit=1.
  - Saturates at 2^CNT_W - 1; there is no wrap.
  - Cleared only by iRst.
- Mode is per operation, carried down the pipe. Mixed modes in flight are legal.
- Operand 0 in any position gives result 0 and hit 0.

Decomposition:
- Package appr_mult_pkg:
  - Localparams for the digit width (2), the approximate 3*3 value (7), and the exact value (9).
  - A function computing the 2x2 unit.
- One sub-module, appr_mult_unit2:
  - Combinational 2x2 multiplier with a mode input.
  - Output: 4-bit result plus a hit bit.
  - Instantiated NDIG*NDIG times in S2.

Test Plan:
- WIDTH=8, iMode=1, 255*255, iReady=1 -> oResult=50575, oApproxHit=1, 3 cycles after accept; same operands with iMode=0 -> 65025, hit=0.
- WIDTH=8, iMode=1, 12*5 (no 3*3 digit pair) -> 60, hit=0; 3*3 -> 7, hit=1, oHitCnt=1; 3*3 with iMode=0 -> 9, hit=0.
- Backpressure: iReady=0, iValid=1 streaming 1*1, 2*2, 3*3 (mode 0), 4*4 -> oReady drops once oValid=1; oResult holds 1 stably; raising iReady delivers 1, 4, 9, 16 in order with no loss or duplication.
- Reset mid-stream: 2 operations in flight, assert iRst for 1 cycle -> oValid=0 and oHitCnt=0 next cycle; neither flushed operation is ever output.
- CNT_W=2: deliver 5 approximate-hit results -> oHitCnt reads 1, 2, 3, 3, 3; a non-hit result leaves it unchanged.
- WIDTH=4 and WIDTH=16 random sweep (1000 ops, random iValid/iReady) against a reference model -> all results, hit flags and ordering match.
